// File: rtl/led_blink_ctrl.sv
// Multi-channel LED controller: shared tick prescaler and PWM counter, per-channel OFF/ON/BLINK/PWM.
// Optional LED_BLINK_CTRL_PHASE_SYNC_EN: a BLINK write also restarts every other blinking channel.
module led_blink_ctrl #(
    parameter int CHANNELS = 4,
    parameter int TICK_DIV = 100_000,
    parameter int PERIOD_W = 16,
    parameter int PWM_W    = 8,
    localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHAN_W-1:0]   cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [PWM_W-1:0]    cfg_duty,
    output logic                cfg_err,
    output logic                tick,
    output logic [CHANNELS-1:0] led
);

    localparam int TICK_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PWM   = 2'b11
    } mode_e;

    logic [TICK_W-1:0]   r_tick_cnt;
    logic [PWM_W-1:0]    r_pwm_cnt;
    logic                r_ready;
    logic                r_err;

    mode_e               r_mode       [CHANNELS];
    logic [PERIOD_W-1:0] r_period     [CHANNELS];
    logic [PWM_W-1:0]    r_duty       [CHANNELS];
    logic [PERIOD_W-1:0] r_bcnt       [CHANNELS];
    logic [CHANNELS-1:0] r_led;

    mode_e               w_mode_nxt   [CHANNELS];
    logic [PERIOD_W-1:0] w_period_nxt [CHANNELS];
    logic [PWM_W-1:0]    w_duty_nxt   [CHANNELS];
    logic [PERIOD_W-1:0] w_bcnt_nxt   [CHANNELS];
    logic [CHANNELS-1:0] w_led_nxt;
    logic [CHANNELS-1:0] w_sel;
    logic [CHANNELS-1:0] w_restart;

    logic                w_tick;
    logic                w_accept;
    logic                w_chan_ok;
    logic                w_wr;
    logic                w_wr_blink;
    logic [PERIOD_W-1:0] w_period_in;

    assign w_tick      = (r_tick_cnt == TICK_W'(TICK_DIV - 1));
    assign w_accept    = cfg_valid && r_ready;
    assign w_chan_ok   = (32'(cfg_chan) < 32'(CHANNELS));
    assign w_wr        = w_accept && w_chan_ok;
    assign w_wr_blink  = w_wr && (cfg_mode == MODE_BLINK);
    assign w_period_in = (cfg_period == '0) ? PERIOD_W'(1) : cfg_period;

    assign tick      = w_tick;
    assign cfg_ready = r_ready;
    assign cfg_err   = r_err;
    assign led       = r_led;

    // A write on the same cycle as a tick wins: restart takes priority over the tick step.
    always_comb begin
        w_led_nxt = r_led;
        w_sel     = '0;
        w_restart = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_sel[i] = w_wr && (cfg_chan == CHAN_W'(i));
`ifdef LED_BLINK_CTRL_PHASE_SYNC_EN
            w_restart[i] = w_wr_blink && (w_sel[i] || (r_mode[i] == MODE_BLINK));
`else
            w_restart[i] = w_wr_blink && w_sel[i];
`endif
            w_mode_nxt[i]   = w_sel[i] ? mode_e'(cfg_mode) : r_mode[i];
            w_period_nxt[i] = w_sel[i] ? w_period_in : r_period[i];
            w_duty_nxt[i]   = w_sel[i] ? cfg_duty : r_duty[i];
            w_bcnt_nxt[i]   = r_bcnt[i];

            case (w_mode_nxt[i])
                MODE_OFF: w_led_nxt[i] = 1'b0;
                MODE_ON:  w_led_nxt[i] = 1'b1;
                MODE_PWM: w_led_nxt[i] = (r_pwm_cnt < w_duty_nxt[i]);
                MODE_BLINK: begin
                    if (w_restart[i]) begin
                        w_bcnt_nxt[i] = '0;
                        w_led_nxt[i]  = 1'b1;
                    end else if (w_tick) begin
                        if (r_bcnt[i] == r_period[i] - 1'b1) begin
                            w_bcnt_nxt[i] = '0;
                            w_led_nxt[i]  = ~r_led[i];
                        end else begin
                            w_bcnt_nxt[i] = r_bcnt[i] + 1'b1;
                        end
                    end
                end
                default: w_led_nxt[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_tick_cnt <= '0;
            r_pwm_cnt  <= '0;
            r_ready    <= 1'b1;
            r_err      <= 1'b0;
            r_led      <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_mode[i]   <= MODE_OFF;
                r_period[i] <= PERIOD_W'(1);
                r_duty[i]   <= '0;
                r_bcnt[i]   <= '0;
            end
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_pwm_cnt  <= r_pwm_cnt + 1'b1;
            r_ready    <= !w_accept;
            r_err      <= w_accept && !w_chan_ok;
            r_led      <= w_led_nxt;
            for (int i = 0; i < CHANNELS; i++) begin
                r_mode[i]   <= w_mode_nxt[i];
                r_period[i] <= w_period_nxt[i];
                r_duty[i]   <= w_duty_nxt[i];
                r_bcnt[i]   <= w_bcnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed bench for led_blink_ctrl: CHANNELS=5, TICK_DIV=4, PWM_W=8.
// Phase-sync expectations follow LED_BLINK_CTRL_PHASE_SYNC_EN when defined for the build.
module tb_led_blink_ctrl;

    localparam int CH = 5;
    localparam int TD = 4;
    localparam int PW = 16;
    localparam int DW = 8;
    localparam int CW = 3;

    logic          clk        = 1'b0;
    logic          n_reset    = 1'b0;
    logic          cfg_valid  = 1'b0;
    logic [CW-1:0] cfg_chan   = '0;
    logic [1:0]    cfg_mode   = '0;
    logic [PW-1:0] cfg_period = '0;
    logic [DW-1:0] cfg_duty   = '0;
    logic          cfg_ready;
    logic          cfg_err;
    logic          tick;
    logic [CH-1:0] led;

    int n_chk  = 0;
    int n_pass = 0;
    int m_tcnt;

    led_blink_ctrl #(
        .CHANNELS (CH),
        .TICK_DIV (TD),
        .PERIOD_W (PW),
        .PWM_W    (DW)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .cfg_err    (cfg_err),
        .tick       (tick),
        .led        (led)
    );

    always #5 clk = ~clk;

    // Reference tick phase: the tick fires on the edge following a cycle where this is TD-1.
    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) m_tcnt <= 0;
        else          m_tcnt <= (m_tcnt == TD - 1) ? 0 : m_tcnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wr(input int ch, input logic [1:0] mode, input int per, input int duty);
        int w;
        w = 0;
        cfg_valid  = 1'b1;
        cfg_chan   = CW'(ch);
        cfg_mode   = mode;
        cfg_period = PW'(per);
        cfg_duty   = DW'(duty);
        while (cfg_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("wr_ready", 32'(cfg_ready), 1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_toggle(input int ch, output int cycles, output int ticks);
        logic prev;
        prev   = led[ch];
        cycles = 0;
        ticks  = 0;
        while (cycles < 200) begin
            if (m_tcnt == TD - 1) ticks++;
            @(negedge clk);
            cycles++;
            if (led[ch] !== prev) break;
        end
    endtask

    initial begin
        int cyc;
        int tk;
        int hi;
        int mism;

        repeat (3) @(negedge clk);
        check("rst_led",   32'(led), 0);
        check("rst_ready", 32'(cfg_ready), 1);
        check("rst_err",   32'(cfg_err), 0);
        check("rst_tick",  32'(tick), 0);

        n_reset = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("tick_pos", 32'(tick), 32'(k % 4 == 3));
        end
        check("idle_led", 32'(led), 0);

        wr(1, 2'b01, 1, 0);
        check("on_led",   32'(led), 2);
        check("on_ready", 32'(cfg_ready), 0);
        @(negedge clk);
        check("on_ready_back", 32'(cfg_ready), 1);
        check("on_led_hold",   32'(led), 2);

        wr(0, 2'b10, 3, 0);
        check("blk3_entry", 32'(led[0]), 1);
        wait_toggle(0, cyc, tk);
        check("blk3_first_ticks", tk, 3);
        check("blk3_first_level", 32'(led[0]), 0);
        wait_toggle(0, cyc, tk);
        check("blk3_low_cycles", cyc, 12);
        wait_toggle(0, cyc, tk);
        check("blk3_high_cycles", cyc, 12);

        wr(0, 2'b10, 0, 0);
        check("blk0_entry", 32'(led[0]), 1);
        wait_toggle(0, cyc, tk);
        check("blk0_first_ticks", tk, 1);
        wait_toggle(0, cyc, tk);
        check("blk0_cycles_a", cyc, 4);
        wait_toggle(0, cyc, tk);
        check("blk0_cycles_b", cyc, 4);

        wr(2, 2'b11, 1, 64);
        hi = 0;
        repeat (256) begin
            @(negedge clk);
            if (led[2]) hi++;
        end
        check("pwm64_high", hi, 64);

        wr(2, 2'b11, 1, 255);
        hi = 0;
        repeat (256) begin
            @(negedge clk);
            if (led[2]) hi++;
        end
        check("pwm255_high", hi, 255);

        wr(2, 2'b11, 1, 0);
        hi = 0;
        repeat (256) begin
            @(negedge clk);
            if (led[2]) hi++;
        end
        check("pwm0_high", hi, 0);

        wr(0, 2'b00, 1, 0);
        check("off_led", 32'(led), 2);

        wr(5, 2'b01, 1, 0);
        check("inv_err",  32'(cfg_err), 1);
        check("inv_led",  32'(led), 2);
        @(negedge clk);
        check("inv_err_clear", 32'(cfg_err), 0);
        check("inv_led_hold",  32'(led), 2);

        cfg_valid = 1'b1;
        cfg_chan  = CW'(6);
        cfg_mode  = 2'b01;
        @(negedge clk);
        check("hold_err_1",   32'(cfg_err), 1);
        check("hold_ready_1", 32'(cfg_ready), 0);
        @(negedge clk);
        check("hold_err_2",   32'(cfg_err), 0);
        check("hold_ready_2", 32'(cfg_ready), 1);
        @(negedge clk);
        check("hold_err_3",   32'(cfg_err), 1);
        check("hold_ready_3", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        @(negedge clk);
        check("hold_err_4",   32'(cfg_err), 0);
        check("hold_led",     32'(led), 2);

        wr(0, 2'b10, 3, 0);
        wait_toggle(0, cyc, tk);
        repeat (2) @(negedge clk);
        wr(3, 2'b10, 3, 0);
        check("sync_led3", 32'(led[3]), 1);
`ifdef LED_BLINK_CTRL_PHASE_SYNC_EN
        check("sync_led0_restart", 32'(led[0]), 1);
        mism = 0;
        repeat (60) begin
            @(negedge clk);
            if (led[0] !== led[3]) mism++;
        end
        check("sync_aligned", mism, 0);
`else
        check("nosync_led0_kept", 32'(led[0]), 0);
        repeat (10) @(negedge clk);
`endif

        n_reset = 1'b0;
        #1;
        check("arst_led",   32'(led), 0);
        check("arst_ready", 32'(cfg_ready), 1);
        @(negedge clk);
        n_reset = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_led", 32'(led), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
